// File: rtl/fc_pkg.sv
// fc_pkg: width helpers, state type and output saturation for fc_neuron_stream
package fc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int acc_width(input int in_w, input int w_w, input int n_in);
    return in_w + w_w + clog2(n_in) + 1;
  endfunction
  function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    return v > hi ? hi : v < ~hi ? ~hi : v;
  endfunction
endpackage

// File: rtl/fc_lane_dot.sv
// fc_lane_dot: combinational LANES-wide signed multiply and sum into an ACC_W-wide beat total
module fc_lane_dot
  import fc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 30,
  parameter int W_W   = 9,
  parameter int ACC_W = 52
) (
  input  logic [LANES*IN_W-1:0]   in_data,
  input  logic [LANES*W_W-1:0]    w_data,
  output logic signed [ACC_W-1:0] sum
);
  localparam int P_W = IN_W + W_W;
  logic signed [P_W-1:0] prod [LANES];
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign prod[g] = P_W'($signed(in_data[g*IN_W +: IN_W])) * P_W'($signed(w_data[g*W_W +: W_W]));
  end
  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) sum = sum + ACC_W'(prod[l]);
  end
endmodule

// File: rtl/fc_neuron_stream.sv
// fc_neuron_stream: streamed FC neuron sum(x*w)+b with saturated output; define FC_RELU_EN to clamp negatives to 0
module fc_neuron_stream
  import fc_pkg::*;
#(
  parameter int N_IN  = 3136,
  parameter int LANES = 4,
  parameter int IN_W  = 30,
  parameter int W_W   = 9,
  parameter int B_W   = 9,
  parameter int OUT_W = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [B_W-1:0]   bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*IN_W-1:0]   in_data,
  input  logic [LANES*W_W-1:0]    w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy
);
  localparam int ACC_W = acc_width(IN_W, W_W, N_IN);
  localparam int BEATS = N_IN / LANES;
  localparam int CW    = clog2(BEATS) + 1;
  state_t state;
  logic signed [ACC_W-1:0] acc, beat_sum, acc_b;
  logic signed [B_W-1:0] bias_r;
  logic [CW-1:0] cnt;
  logic signed [OUT_W-1:0] sat, res;
  fc_lane_dot #(.LANES(LANES), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W)) u_dot (
    .in_data(in_data),
    .w_data(w_data),
    .sum(beat_sum)
  );
  assign acc_b = acc + ACC_W'(bias_r);
  assign sat = OUT_W'(saturate(128'(acc_b), OUT_W));
`ifdef FC_RELU_EN
  assign res = sat[OUT_W-1] ? '0 : sat;
`else
  assign res = sat;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      bias_r    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bias_r   <= bias;
          acc      <= '0;
          cnt      <= '0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          state    <= ACCUM;
        end
        ACCUM: if (in_valid && in_ready) begin
          acc <= acc + beat_sum;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(BEATS - 1)) begin
            in_ready <= 1'b0;
            state    <= BIAS;
          end
        end
        BIAS: begin
          acc       <= acc_b;
          out_data  <= res;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_neuron_stream.sv
// tb_fc_neuron_stream: directed checks on an 8-input/16-bit instance plus a default-size run against a model
module tb_fc_neuron_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic s_start = 0, s_in_valid = 0, s_out_ready = 0;
  logic signed [8:0] s_bias = '0;
  logic [119:0] s_in_data = '0;
  logic [35:0] s_w_data = '0;
  logic s_in_ready, s_out_valid, s_busy;
  logic signed [15:0] s_out_data;
  logic b_start = 0, b_in_valid = 0, b_out_ready = 0;
  logic signed [8:0] b_bias = '0;
  logic [119:0] b_in_data = '0;
  logic [35:0] b_w_data = '0;
  logic b_in_ready, b_out_valid, b_busy;
  logic signed [37:0] b_out_data;
  int xs [8];
  int ws [8];
  fc_neuron_stream #(.N_IN(8), .LANES(4), .IN_W(30), .W_W(9), .B_W(9), .OUT_W(16)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .bias(s_bias),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .w_data(s_w_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
  );
  fc_neuron_stream u_big (
    .clk(clk), .rst(rst), .start(b_start), .bias(b_bias),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .w_data(b_w_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic longint relu(input longint v);
`ifdef FC_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic s_load(input int k);
    for (int l = 0; l < 4; l++) begin
      s_in_data[l*30 +: 30] = 30'(xs[k*4+l]);
      s_w_data[l*9 +: 9] = 9'(ws[k*4+l]);
    end
  endtask
  task automatic s_run(input int b, input bit gaps, input int hold, input longint exp, input string tag);
    s_bias = 9'(b);
    s_start = 1;
    tick;
    s_start = 0;
    check({tag, ":busy"}, longint'(s_busy), 1);
    check({tag, ":ready"}, longint'(s_in_ready), 1);
    for (int k = 0; k < 2; k++) begin
      if (gaps) begin
        s_in_valid = 0;
        repeat ($urandom_range(1, 3)) tick;
        check({tag, ":gap_ready"}, longint'(s_in_ready), 1);
      end
      s_load(k);
      s_in_valid = 1;
      tick;
    end
    s_in_valid = 0;
    check({tag, ":lat1_valid"}, longint'(s_out_valid), 0);
    check({tag, ":bias_ready"}, longint'(s_in_ready), 0);
    tick;
    check({tag, ":lat2_valid"}, longint'(s_out_valid), 1);
    check({tag, ":data"}, longint'(s_out_data), exp);
    s_start = hold > 0;
    repeat (hold) begin
      tick;
      check({tag, ":hold_valid"}, longint'(s_out_valid), 1);
      check({tag, ":hold_data"}, longint'(s_out_data), exp);
      check({tag, ":hold_ready"}, longint'(s_in_ready), 0);
    end
    s_out_ready = 1;
    tick;
    s_out_ready = 0;
    s_start = 0;
    check({tag, ":valid_drop"}, longint'(s_out_valid), 0);
    check({tag, ":busy_drop"}, longint'(s_busy), 0);
  endtask
  task automatic b_run(input int xr, input string tag);
    longint acc, hi;
    int bb, xv, wv;
    acc = 0;
    hi = (longint'(1) << 37) - 1;
    bb = int'($urandom_range(0, 511)) - 256;
    b_bias = 9'(bb);
    b_start = 1;
    tick;
    b_start = 0;
    for (int k = 0; k < 784; k++) begin
      for (int l = 0; l < 4; l++) begin
        xv = xr > 0 ? int'($urandom_range(0, 2 * xr)) - xr : int'($urandom) >>> 2;
        wv = int'($urandom_range(0, 511)) - 256;
        b_in_data[l*30 +: 30] = 30'(xv);
        b_w_data[l*9 +: 9] = 9'(wv);
        acc += longint'(xv) * longint'(wv);
      end
      b_in_valid = 1;
      b_start = (k % 97) == 5;
      tick;
    end
    b_in_valid = 0;
    b_start = 0;
    acc += bb;
    acc = acc > hi ? hi : acc < -hi - 1 ? -hi - 1 : acc;
    check({tag, ":ready_after_784"}, longint'(b_in_ready), 0);
    tick;
    check({tag, ":valid"}, longint'(b_out_valid), 1);
    check({tag, ":data"}, longint'(b_out_data), relu(acc));
    b_out_ready = 1;
    tick;
    b_out_ready = 0;
    check({tag, ":busy_drop"}, longint'(b_busy), 0);
  endtask
  initial begin
    repeat (2) tick;
    check("rst_in_ready", longint'(s_in_ready), 0);
    check("rst_out_valid", longint'(s_out_valid), 0);
    check("rst_busy", longint'(s_busy), 0);
    rst = 0;
    tick;
    check("idle_out_data", longint'(s_out_data), 0);
    check("idle_big_busy", longint'(b_busy), 0);
    s_out_ready = 1;
    tick;
    s_out_ready = 0;
    check("idle_out_ready_ignored", longint'(s_out_valid), 0);
    check("idle_busy", longint'(s_busy), 0);
    xs = '{1, 2, 3, 4, 5, 6, 7, 8};
    ws = '{1, 1, 1, 1, 1, 1, 1, 1};
    s_run(3, 0, 0, relu(39), "ramp");
    xs = '{-5, -5, -5, -5, -5, -5, -5, -5};
    ws = '{2, 2, 2, 2, 2, 2, 2, 2};
    s_run(-1, 0, 0, relu(-81), "neg");
    xs = '{536870911, 536870911, 536870911, 536870911, 536870911, 536870911, 536870911, 536870911};
    ws = '{255, 255, 255, 255, 255, 255, 255, 255};
    s_run(255, 0, 0, relu(32767), "sat_pos");
    ws = '{-255, -255, -255, -255, -255, -255, -255, -255};
    s_run(255, 0, 0, relu(-32768), "sat_neg");
    xs = '{1, 2, 3, 4, 5, 6, 7, 8};
    ws = '{2, -1, 3, 0, -4, 5, 1, -2};
    s_run(7, 1, 5, relu(17), "backpressure");
    xs = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    ws = '{100, 100, 100, 100, 100, 100, 100, 100};
    s_bias = 9'(100);
    s_start = 1;
    tick;
    s_start = 0;
    s_load(0);
    s_in_valid = 1;
    tick;
    s_load(1);
    rst = 1;
    tick;
    rst = 0;
    s_in_valid = 0;
    check("abort_ready", longint'(s_in_ready), 0);
    check("abort_busy", longint'(s_busy), 0);
    check("abort_out_data", longint'(s_out_data), 0);
    tick;
    check("abort_out_valid", longint'(s_out_valid), 0);
    xs = '{1, 1, 1, 1, 1, 1, 1, 1};
    ws = '{1, 1, 1, 1, 1, 1, 1, 1};
    s_run(0, 0, 0, relu(8), "fresh");
    b_run(1 << 20, "big_small_x");
    b_run(0, "big_full_x");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
